// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency imem
// reads, buffers {inst, pc} in a small FWFT queue, and handles redirect and halt.
module fetch_queue_unit #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              halted
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc, inflight_pc;
  logic              inflight, kill, halted_q;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [DATA_W-1:0] q_inst [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];

  logic issue, push, pop, is_halt;
  logic [CW:0] occupancy;

  // Counting the in-flight read against capacity guarantees every response has a slot.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue     = reset & ~halted_q & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
  assign push      = inflight & ~kill & ~redirect_valid;
  assign pop       = inst_valid & inst_ready;
  assign is_halt   = (imem_rdata[DATA_W-1 -: 6] == 6'd31);

  assign imem_en    = issue;
  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? q_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;
  assign halted     = halted_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= '0;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      halted_q    <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      inflight <= issue;
      // Drops the response that lands the cycle after a halt push or a redirect.
      kill     <= redirect_valid | (push & is_halt);
      if (issue) begin
        fetch_pc    <= fetch_pc + 1'b1;
        inflight_pc <= fetch_pc;
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        halted_q <= 1'b0;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (is_halt) halted_q <= 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: startup latency, backpressure, redirect,
// halt, PC wrap and mid-stream reset, against a 1-cycle registered imem model.
module tb_fetch_queue_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_en;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [8:0]  inst_pc;
  logic        inst_ready;
  logic        halted;

  logic        halt_en;
  logic [8:0]  halt_addr;
  int          tests = 0;
  int          fails = 0;

  fetch_queue_unit #(.ADDR_W(9), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [8:0] a);
    if (halt_en && a == halt_addr) return 32'h7C00_0003;
    return 32'h0000_0100 + {23'b0, a};
  endfunction

  always @(posedge clk) if (imem_en) imem_rdata <= word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Leaves the bench in cycle 0: first cycle after reset deasserts, outputs settled.
  task automatic do_reset();
    reset = 1'b0;
    step(); step();
    reset = 1'b1; #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b1; halt_en = 1'b0; halt_addr = 9'd3;
    #2;
    chk("rst_en", imem_en, 0);      chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0); chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);      chk("rst_halt", halted, 0);

    // startup latency and streaming
    do_reset();
    chk("t1_c0_en", imem_en, 1); chk("t1_c0_addr", imem_addr, 0); chk("t1_c0_valid", inst_valid, 0);
    step();
    chk("t1_c1_addr", imem_addr, 1); chk("t1_c1_valid", inst_valid, 0);
    step();
    chk("t1_c2_valid", inst_valid, 1); chk("t1_c2_pc", inst_pc, 0); chk("t1_c2_inst", inst, 32'h100);
    for (int c = 3; c <= 5; c++) begin
      step();
      chk("t1_pc", inst_pc, c - 2); chk("t1_addr", imem_addr, c); chk("t1_valid", inst_valid, 1);
    end

    // backpressure fills exactly DEPTH entries
    inst_ready = 1'b0;
    do_reset();
    for (int c = 1; c <= 3; c++) step();
    step();
    chk("t2_c4_en", imem_en, 0);
    for (int c = 5; c <= 10; c++) begin
      step();
      chk("t2_stall_en", imem_en, 0); chk("t2_stall_pc", inst_pc, 0); chk("t2_stall_valid", inst_valid, 1);
    end
    inst_ready = 1'b1;
    for (int c = 11; c <= 15; c++) begin
      step();
      chk("t2_drain_pc", inst_pc, c - 10); chk("t2_drain_valid", inst_valid, 1);
      if (c == 11) begin chk("t2_resume_en", imem_en, 1); chk("t2_resume_addr", imem_addr, 4); end
      if (c == 12) chk("t2_c12_addr", imem_addr, 5);
    end

    // redirect flushes queue and in-flight response
    inst_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 7; c++) step();
    chk("t3_c7_pc", inst_pc, 5);
    inst_ready = 1'b0;
    step();
    chk("t3_c8_pc", inst_pc, 5); chk("t3_c8_addr", imem_addr, 8); chk("t3_c8_en", imem_en, 1);
    step();
    chk("t3_c9_pc", inst_pc, 5); chk("t3_c9_en", imem_en, 0);
    redirect_valid = 1'b1; redirect_pc = 9'd40; #1;
    chk("t3_redir_en", imem_en, 0);
    step(); redirect_valid = 1'b0; #1;
    chk("t3_c10_valid", inst_valid, 0); chk("t3_c10_en", imem_en, 1); chk("t3_c10_addr", imem_addr, 40);
    step();
    chk("t3_c11_valid", inst_valid, 0); chk("t3_c11_addr", imem_addr, 41);
    step();
    chk("t3_c12_valid", inst_valid, 1); chk("t3_c12_pc", inst_pc, 40); chk("t3_c12_inst", inst, 32'h128);
    inst_ready = 1'b1;
    step();
    chk("t3_c13_pc", inst_pc, 41); chk("t3_c13_inst", inst, 32'h129);

    // halt at address 3
    halt_en = 1'b1; halt_addr = 9'd3;
    do_reset();
    for (int c = 1; c <= 4; c++) step();
    chk("t4_c4_halt", halted, 0); chk("t4_c4_addr", imem_addr, 4); chk("t4_c4_pc", inst_pc, 2);
    step();
    chk("t4_c5_pc", inst_pc, 3); chk("t4_c5_inst", inst, 32'h7C00_0003);
    chk("t4_c5_halt", halted, 1); chk("t4_c5_en", imem_en, 0);
    step();
    chk("t4_c6_valid", inst_valid, 0); chk("t4_c6_en", imem_en, 0);
    step();
    chk("t4_c7_valid", inst_valid, 0); chk("t4_c7_en", imem_en, 0); chk("t4_c7_halt", halted, 1);
    redirect_valid = 1'b1; redirect_pc = 9'd0; halt_en = 1'b0;
    step(); redirect_valid = 1'b0; #1;
    chk("t4_c8_halt", halted, 0); chk("t4_c8_en", imem_en, 1); chk("t4_c8_addr", imem_addr, 0);
    step(); step();
    chk("t4_c10_valid", inst_valid, 1); chk("t4_c10_pc", inst_pc, 0); chk("t4_c10_inst", inst, 32'h100);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 9'h1FE;
    step(); redirect_valid = 1'b0; #1;
    chk("t5_addr_1fe", imem_addr, 9'h1FE); chk("t5_en", imem_en, 1);
    step();
    chk("t5_addr_1ff", imem_addr, 9'h1FF);
    step();
    chk("t5_addr_wrap", imem_addr, 0); chk("t5_pc_1fe", inst_pc, 9'h1FE); chk("t5_inst_1fe", inst, 32'h2FE);
    step();
    chk("t5_pc_1ff", inst_pc, 9'h1FF); chk("t5_inst_1ff", inst, 32'h2FF);
    step();
    chk("t5_pc_0", inst_pc, 0); chk("t5_inst_0", inst, 32'h100);

    // mid-stream reset with 3 entries queued
    inst_ready = 1'b0;
    do_reset();
    for (int c = 1; c <= 4; c++) step();
    chk("t6_pre_valid", inst_valid, 1); chk("t6_pre_pc", inst_pc, 0);
    reset = 1'b0; #1;
    chk("t6_rst_valid", inst_valid, 0); chk("t6_rst_en", imem_en, 0);
    chk("t6_rst_addr", imem_addr, 0); chk("t6_rst_halt", halted, 0);
    step(); step();
    reset = 1'b1; #1;
    chk("t6_rel_en", imem_en, 1); chk("t6_rel_addr", imem_addr, 0); chk("t6_rel_valid", inst_valid, 0);
    step(); step();
    chk("t6_first_valid", inst_valid, 1); chk("t6_first_pc", inst_pc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle ALU/branch execute stage.
- Owns the fetch PC and issues word reads to the synchronous instruction memory (1-cycle read latency).
- Buffers returned words with their PC in a small FIFO and presents them to execute over a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushes stale work, and stops fetching after the halt opcode (31).

Parameters:
ADDR_W, 9, instruction word-address width (matches 9-bit PC/imem address).
DATA_W, 32, instruction width.
DEPTH, 4, fetch queue entries (power of two, >=2).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset.
imem_en  output  1  read request to instruction memory this cycle.
imem_addr  output  ADDR_W  read address; valid when imem_en=1.
imem_rdata  input  DATA_W  read data; valid exactly one cycle after the cycle imem_en=1.
redirect_valid  input  1  execute requests PC change (taken branch, j, jr, jal).
redirect_pc  input  ADDR_W  new fetch address.
inst_valid  output  1  queue head holds a valid instruction.
inst  output  DATA_W  queue head instruction.
inst_pc  output  ADDR_W  address of inst.
inst_ready  input  1  execute consumes head when inst_valid & inst_ready.
halted  output  1  halt opcode (inst[31:26]==31) captured; fetching stopped.

Behaviour:
- Reset (reset=0, async): fetch_pc=0, queue empty, inflight=0, halted=0; outputs inst_valid=0, inst=0, inst_pc=0, imem_en=0, imem_addr=0.
- Issue rule (combinational): imem_en = !halted & !redirect_valid & (count + inflight < DEPTH), using registered count and inflight. imem_addr=fetch_pc. On issue: fetch_pc <= fetch_pc+1 (wraps mod 2^ADDR_W), inflight <= 1, and the issued PC is captured into the inflight_pc register.
- Response: in the cycle after an issue, if the response is not killed, push {imem_rdata, inflight_pc} into the queue at the end of that cycle. inflight clears unless a new issue occurs the same cycle.
- Latency: issue in cycle N; data on imem_rdata in N+1; inst_valid=1 in N+2 (queue is registered, no bypass).
- Throughput: with inst_ready held high, one instruction per cycle sustained after the first.
- Output: inst, inst_pc and inst_valid come from the queue head (first-word fall-through). Pop on inst_valid & inst_ready. Push and pop in the same cycle leave count unchanged.
- Queue full: the issue rule guarantees a response always has space; overflow is illegal and must be asserted in simulation.
- Redirect (highest priority, same cycle):
  - queue flushed (count <- 0, inst_valid=0 next cycle);
  - any response arriving this cycle or next from a pre-redirect issue is discarded (kill flag);
  - fetch_pc <- redirect_pc; halted <- 0;
  - no issue in the redirect cycle; first issue at redirect_pc the following cycle;
  - a pop in the same cycle is still honoured by execute, but queue state is cleared regardless.
- Halt: when a pushed word has inst[31:26]==31, set halted=1 at that edge. Stop issuing. A response arriving in the cycle after the halt push is discarded. The halt word itself stays in the queue and is delivered normally. Only reset or redirect clears halted.
- Reset mid-operation: all state and outputs return to reset values immediately; the next read issues at address 0 in the first clock after reset deasserts.
- Arithmetic: PC increment and compare are unsigned ADDR_W wide. redirect_pc is used as-is (the target is computed in execute).

Test Plan:
- Reset release, imem holds addr k = 32'h0000_0100+k, inst_ready=1 -> imem_en high from cycle 0 with addr 0,1,2...; inst_valid first high in cycle 2 with inst_pc=0; inst_pc then increments by 1 every cycle.
- inst_ready=0 for 10 cycles -> exactly DEPTH=4 words buffered (pc 0..3), imem_en low once count+inflight=4; on release, pc 0..3 delivered back-to-back, then fetch resumes at 4 with no gaps or duplicates.
- redirect_valid=1, redirect_pc=9'd40 while queue holds pc 5..7 and one read is in flight -> inst_valid=0 next cycle, stale pc 8 response dropped, next delivered inst_pc=40, then 41.
- Halt word (opcode 31) at address 3 -> words at pc 0..3 delivered; halted=1; no imem_en afterwards; the pc 4 response is discarded; a later redirect to 0 clears halted and refetches from 0.
- fetch_pc=9'h1FF with no redirect -> next issued address 9'h000 (wrap).
- Assert reset low mid-stream with queue holding 3 entries -> inst_valid=0 and imem_en=0 immediately; after release the first issue is at addr 0.
